// File: rtl/timer_pkg.sv
// timer_pkg: register map, tap table and channel state shared by the DIV/TIMA timer block
package timer_pkg;
  localparam int REG_DIV = 0;
  localparam int REG_TIMA = 1;
  localparam int REG_TMA = 2;
  localparam int REG_TAC = 3;
  localparam int REG_STRIDE = 4;
  localparam int TAC_TAP [4] = '{9, 3, 5, 7};
  localparam int FS_BIT = 12;
  localparam int OVF_CYC = 4;
  typedef enum logic [1:0] {RUN, OVF, RELOAD} ch_state_t;
  function automatic logic tap_sig(input logic [FS_BIT:0] d, input logic [2:0] tac);
    return d[TAC_TAP[tac[1:0]]] & tac[2];
  endfunction
endpackage

// File: rtl/timer_channel.sv
// timer_channel: one TIMA/TMA/TAC timer with falling-edge tap detect and DMG overflow/reload delay
module timer_channel
  import timer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [FS_BIT:0]   div,
  input  logic [FS_BIT:0]   div_nxt,
  input  logic              div_wr,
  input  logic              wr_tima,
  input  logic              wr_tma,
  input  logic              wr_tac,
  input  logic [7:0]        din,
  output logic [7:0]        tima,
  output logic [7:0]        tma,
  output logic [2:0]        tac,
  output logic              irq
);
`ifdef TIMER_EDGE_GLITCH_EN
  localparam bit GLITCH = 1'b1;
`else
  localparam bit GLITCH = 1'b0;
`endif
  ch_state_t state, state_nxt;
  logic [1:0] cnt, cnt_nxt;
  logic [7:0] tima_nxt;
  logic sig, sig_nxt, sig_prev, inc;
  assign sig = tap_sig(div, tac);
  assign sig_nxt = tap_sig(div_nxt, wr_tac ? din[2:0] : tac);
  assign inc = sig_prev & ~sig;
  assign irq = state == RELOAD;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= RUN;
      cnt <= '0;
      tima <= '0;
      tma <= '0;
      tac <= '0;
      sig_prev <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      tima <= tima_nxt;
      // without the glitch feature, a DIV/TAC write re-seeds the detector so it sees no edge
      sig_prev <= (!GLITCH && (div_wr || wr_tac)) ? sig_nxt : sig;
      if (wr_tma) tma <= din;
      if (wr_tac) tac <= din[2:0];
    end
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    tima_nxt = tima;
    case (state)
      RUN:
        if (wr_tima) tima_nxt = din;
        else if (inc) begin
          tima_nxt = tima + 8'd1;
          state_nxt = tima == 8'hFF ? OVF : RUN;
          cnt_nxt = '0;
        end
      OVF:
        if (wr_tima) begin
          tima_nxt = din;
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt + 2'd1;
          state_nxt = cnt == 2'(OVF_CYC - 1) ? RELOAD : OVF;
          tima_nxt = cnt == 2'(OVF_CYC - 1) ? (wr_tma ? din : tma) : tima;
        end
      default: begin
        state_nxt = RUN;
        tima_nxt = wr_tma ? din : tima;
      end
    endcase
  end
endmodule

// File: rtl/timer_div_multi.sv
// timer_div_multi: shared DIV counter driving N_CH TIMA channels, register bus and 512 Hz frame tick
// Build option TIMER_EDGE_GLITCH_EN: DIV/TAC writes that drop the tap signal count as a TIMA edge.
module timer_div_multi
  import timer_pkg::*;
#(
  parameter int DIV_W = 16,
  parameter int N_CH = 1,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr,
  input  logic [7:0]        din,
  input  logic              rd,
  output logic [7:0]        dout,
  output logic [N_CH-1:0]   irq,
  output logic              fs_tick
);
  logic [DIV_W-1:0] div, div_nxt;
  logic div_wr, fs_prev;
  logic [1:0] sel;
  logic [ADDR_W-1:0] ch_idx;
  logic [7:0] rdata;
  logic [7:0] tima [N_CH];
  logic [7:0] tma [N_CH];
  logic [2:0] tac [N_CH];
  assign sel = addr[1:0];
  assign ch_idx = addr >> $clog2(REG_STRIDE);
  assign div_wr = wr && addr == ADDR_W'(REG_DIV);
  assign div_nxt = div_wr ? '0 : div + DIV_W'(1);
  assign fs_tick = fs_prev & ~div[FS_BIT];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      div <= '0;
      fs_prev <= 1'b0;
    end else begin
      div <= div_nxt;
      fs_prev <= div[FS_BIT];
    end
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic hit;
    assign hit = wr && ch_idx == ADDR_W'(c);
    timer_channel u_ch (
      .clk(clk),
      .reset(reset),
      .div(div[FS_BIT:0]),
      .div_nxt(div_nxt[FS_BIT:0]),
      .div_wr(div_wr),
      .wr_tima(hit && sel == 2'(REG_TIMA)),
      .wr_tma(hit && sel == 2'(REG_TMA)),
      .wr_tac(hit && sel == 2'(REG_TAC)),
      .din(din),
      .tima(tima[c]),
      .tma(tma[c]),
      .tac(tac[c]),
      .irq(irq[c])
    );
  end
  // index 4c with c>0 and anything past the last channel fall through to FF
  always_comb begin
    rdata = addr == ADDR_W'(REG_DIV) ? div[DIV_W-1 -: 8] : 8'hFF;
    for (int i = 0; i < N_CH; i++)
      if (ch_idx == ADDR_W'(i))
        rdata = sel == 2'(REG_TIMA) ? tima[i] :
                sel == 2'(REG_TMA)  ? tma[i]  :
                sel == 2'(REG_TAC)  ? {5'h1F, tac[i]} : rdata;
    dout = rd ? rdata : 8'hFF;
  end
endmodule

// File: tb/tb_timer_div_multi.sv
// tb_timer_div_multi: directed vectors for timer_div_multi (N_CH=2) checked through a read scoreboard
module tb_timer_div_multi;
`ifdef TIMER_EDGE_GLITCH_EN
  localparam bit G = 1'b1;
`else
  localparam bit G = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, wr = 1'b0, rd = 1'b0;
  logic [3:0] addr = '0;
  logic [7:0] din = '0, dout;
  logic [1:0] irq;
  logic fs_tick;
  int nvec = 0, nerr = 0, cyc = 0, base = 0, irq0_cnt = 0, fs_cnt = 0, snap = 0;
  string names[$];
  logic [9:0] exps[$];

  timer_div_multi #(.DIV_W(16), .N_CH(2), .ADDR_W(4)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wr(wr), .din(din), .rd(rd),
    .dout(dout), .irq(irq), .fs_tick(fs_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [9:0] e;
    string n;
    if (irq[0]) irq0_cnt++;
    if (fs_tick) fs_cnt++;
    if (rd) begin
      nvec++;
      if (exps.size() == 0) begin
        nerr++;
        $display("FAIL unexpected_read: dout=%h irq=%b with nothing expected", dout, irq);
      end else begin
        e = exps.pop_front();
        n = names.pop_front();
        if (dout !== e[7:0] || irq !== e[9:8]) begin
          nerr++;
          $display("FAIL %s: got dout=%h irq=%b, required dout=%h irq=%b", n, dout, irq, e[7:0], e[9:8]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic at(input int k);
    while (cyc < base + k) tick();
  endtask
  task automatic wreg(input logic [3:0] a, input logic [7:0] d);
    addr = a; din = d; wr = 1'b1;
    tick();
    wr = 1'b0;
  endtask
  task automatic xfer(input string n, input logic [3:0] a, input logic w, input logic [7:0] d,
                      input logic [7:0] ed, input logic [1:0] eq);
    addr = a; din = d; wr = w; rd = 1'b1;
    names.push_back(n);
    exps.push_back({eq, ed});
    tick();
    rd = 1'b0; wr = 1'b0;
  endtask
  task automatic chk(input string n, input logic [3:0] a, input logic [7:0] ed, input logic [1:0] eq);
    xfer(n, a, 1'b0, 8'h00, ed, eq);
  endtask
  task automatic check(input string n, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, required %0d", n, got, exp);
    end
  endtask
  task automatic align();
    wreg(4'd0, 8'h00);
    base = cyc;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    check("rst_dout_idle", dout, 8'hFF);
    check("rst_irq", irq, 0);
    check("rst_fs", fs_tick, 0);
    chk("rst_div", 4'd0, 8'h00, 2'b00);
    chk("rst_tima0", 4'd1, 8'h00, 2'b00);
    chk("rst_tac0", 4'd3, 8'hF8, 2'b00);
    chk("rst_tac1", 4'd7, 8'hF8, 2'b00);
    reset = 1'b0;
    // DIV register counts the upper byte
    repeat (255) tick();
    chk("div_255", 4'd0, 8'h00, 2'b00);
    chk("div_256", 4'd0, 8'h01, 2'b00);
    repeat (255) tick();
    chk("div_512", 4'd0, 8'h02, 2'b00);
    // basic overflow and delayed reload
    wreg(4'd2, 8'h40);
    wreg(4'd1, 8'hFE);
    snap = irq0_cnt;
    align();
    wreg(4'd3, 8'h05);
    at(16); chk("t2_pre", 4'd1, 8'hFE, 2'b00);
    chk("t2_ff", 4'd1, 8'hFF, 2'b00);
    at(32); chk("t2_ff_hold", 4'd1, 8'hFF, 2'b00);
    chk("t2_ovf0", 4'd1, 8'h00, 2'b00);
    at(36); chk("t2_ovf3", 4'd1, 8'h00, 2'b00);
    chk("t2_reload", 4'd1, 8'h40, 2'b01);
    chk("t2_run", 4'd1, 8'h40, 2'b00);
    check("t2_irq_pulses", irq0_cnt - snap, 1);
    // TIMA write during OVF cancels the reload
    snap = irq0_cnt;
    align();
    wreg(4'd1, 8'hFE);
    at(33); chk("t3_ovf", 4'd1, 8'h00, 2'b00);
    xfer("t3_wr_ovf", 4'd1, 1'b1, 8'h10, 8'h00, 2'b00);
    chk("t3_loaded", 4'd1, 8'h10, 2'b00);
    at(40); chk("t3_hold", 4'd1, 8'h10, 2'b00);
    check("t3_no_irq", irq0_cnt - snap, 0);
    // TIMA write during RELOAD is ignored
    align();
    wreg(4'd1, 8'hFE);
    at(37); xfer("t3_wr_reload", 4'd1, 1'b1, 8'h10, 8'h40, 2'b01);
    chk("t3_tma_wins", 4'd1, 8'h40, 2'b00);
    // TMA write during RELOAD lands in TIMA too
    align();
    wreg(4'd1, 8'hFE);
    at(37); xfer("t3_tma_reload", 4'd2, 1'b1, 8'h55, 8'h40, 2'b01);
    chk("t3_tma_into_tima", 4'd1, 8'h55, 2'b00);
    chk("t3_tma_new", 4'd2, 8'h55, 2'b00);
    wreg(4'd2, 8'h40);
    // DIV write while the tap bit is high
    align();
    wreg(4'd1, 8'h20);
    at(8); wreg(4'd0, 8'h00);
    tick();
    chk("t4_div_glitch", 4'd1, G ? 8'h21 : 8'h20, 2'b00);
    // TAC disable while the tap bit is high
    align();
    wreg(4'd1, 8'h20);
    at(8); wreg(4'd3, 8'h01);
    tick();
    chk("t4_tac_glitch", 4'd1, G ? 8'h21 : 8'h20, 2'b00);
    wreg(4'd3, 8'h05);
    // two channels with different taps
    wreg(4'd7, 8'h06);
    wreg(4'd6, 8'h77);
    align();
    wreg(4'd1, 8'hFF);
    wreg(4'd5, 8'hFF);
    at(21); chk("t5_irq0", 4'd1, 8'h40, 2'b01);
    chk("t5_ch1_hold", 4'd5, 8'hFF, 2'b00);
    xfer("t5_wr_ch0", 4'd1, 1'b1, 8'h30, 8'h40, 2'b00);
    chk("t5_ch1_after", 4'd5, 8'hFF, 2'b00);
    chk("t5_ch0_new", 4'd1, 8'h30, 2'b00);
    chk("t5_tma1", 4'd6, 8'h77, 2'b00);
    at(68); chk("t5_ch1_ovf", 4'd5, 8'h00, 2'b00);
    chk("t5_irq1", 4'd5, 8'h77, 2'b10);
    chk("t5_addr4", 4'd4, 8'hFF, 2'b00);
    chk("t5_addr8", 4'd8, 8'hFF, 2'b00);
    chk("t5_addr15", 4'd15, 8'hFF, 2'b00);
    // asynchronous reset while RELOAD is presenting irq
    align();
    wreg(4'd1, 8'hFE);
    at(37);
    check("t6_irq_pre", irq, 2'b01);
    reset = 1'b1;
    #1;
    check("t6_irq_async", irq, 0);
    chk("t6_tima0", 4'd1, 8'h00, 2'b00);
    chk("t6_tma0", 4'd2, 8'h00, 2'b00);
    chk("t6_tima1", 4'd5, 8'h00, 2'b00);
    reset = 1'b0;
    // frame tick: one per 8192 clocks, plus one from a DIV write while div[12]=1
    snap = fs_cnt;
    repeat (8200) tick();
    check("t6_fs_once", fs_cnt - snap, 1);
    align();
    at(5000);
    snap = fs_cnt;
    wreg(4'd0, 8'h00);
    tick();
    check("t6_fs_divwr", fs_cnt - snap, 1);
    tick();
    check("sb_drained", exps.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
